fetch_unit: RTL and testbench
=============================

# fetch_unit

Instruction-fetch stage with an integrated IF/ID pipeline register. It sits directly upstream of the decoder: it owns the PC and issues one-outstanding requests to instruction memory. It presents `{valid, pc, inst}` to ID and redirects on the branch/jump decision that ID returns. There are no delay slots; wrong-path instructions are squashed here.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC loaded at reset; bits [1:0] must be 0.
- `i_clk` in 1: clock; all state updates on the rising edge.
- `i_rst_n` in 1: synchronous, active-low reset.
- `o_memReq` in/out: out 1; instruction-memory request.
- `o_memAddr` out 32: fetch address; held stable while `o_memReq`=1 and no ack.
- `i_memAck` in 1: request completes this cycle; `i_memData` valid.
- `i_memData` in 32: fetched instruction word.
- `i_stall` in 1: hazard stall from downstream; IF/ID must hold.
- `i_takeBranch` in 1: redirect request from ID, for the instruction currently in IF/ID.
- `i_jpc` in 32: redirect target from ID.
- `o_valid` out 1: IF/ID holds a real instruction.
- `o_pc` out 32: PC of the IF/ID instruction; feeds ID.
- `o_inst` out 32: IF/ID instruction; 32'h0 (NOP) when `o_valid`=0.

## Operation
- State machine states:
  - RUN: `o_memReq`=1, `o_memAddr`=pc.
  - DISCARD: `o_memReq`=1, `o_memAddr`=held old address; returned data is dropped.
  - HOLD: `o_memReq`=0; one fetched word is buffered in `hbuf_inst`/`hbuf_pc`.
- `redirect` = `i_takeBranch & o_valid & ~i_stall`. `i_takeBranch` is ignored while stalled or when IF/ID holds a bubble.
- Target alignment: `{i_jpc[31:2], 2'b00}`. pc+4 wraps modulo 2^32.
- RUN, ack, no stall, no redirect: IF/ID ← {1, pc, `i_memData`}; pc ← pc+4; stay in RUN.
- RUN, ack, stall: hold buffer ← {pc, `i_memData`}; pc ← pc+4; go to HOLD; IF/ID unchanged.
- RUN, no ack, no stall: IF/ID ← bubble (valid 0, pc 0, inst 0).
- RUN, no ack, stall: no change.
- RUN, redirect:
  - IF/ID ← bubble; pc ← target.
  - With ack this cycle: data dropped; stay in RUN.
  - Without ack: go to DISCARD.
- DISCARD:
  - On ack: drop data; go to RUN, which issues at pc (the target).
  - IF/ID loads a bubble when not stalled; a later redirect here just overwrites pc.
- HOLD, no stall: IF/ID ← hold buffer; go to RUN.
- HOLD, stall: no change.
- HOLD, redirect: buffer dropped; IF/ID ← bubble; pc ← target; go to RUN.
- Only one request is outstanding. Memory responds solely to a held request; any latency ≥0 cycles beyond the request cycle is legal.

## Timing
- Reset (`i_rst_n`=0 at edge):
  - pc=`RESET_PC`, state=RUN, hold buffer cleared.
  - `o_valid`=0, `o_pc`=0, `o_inst`=0.
  - `o_memReq` is forced to 0 combinationally while `i_rst_n`=0.
- Reset mid-request: the outstanding request is abandoned without a discard. Memory must tolerate the request being withdrawn by reset.
- `o_memReq`/`o_memAddr` are combinational from state and pc; no dependency on `i_memAck`.
- Latency, zero-wait memory: request in cycle N, instruction visible on IF/ID outputs in cycle N+1. Throughput is 1 instruction/cycle.
- Redirect cost: redirect in cycle N gives a bubble in N+1. Target is requested in N+1; it reaches IF/ID in N+2 with zero-wait memory.
- With wait-states, each discarded request costs its full latency plus one cycle.
- Simultaneous stall and ack are fully absorbed by HOLD; no instruction is lost or duplicated.

## Structure
- The shared defines header gains:
  - `FETCH_RUN`, `FETCH_DISCARD`, `FETCH_HOLD` (2-bit encodings).
  - `NOP_INST` (32'h0).
  - It reuses the existing `INST_ADDR_BUS`, `INST_BUS`, `ZERO_WORD`, `ENABLE`, `DISABLE`.
- Single module with no sub-modules. The one-entry hold buffer is small enough to stay inline, and it replaces the standalone IF/ID register.

## Test plan
- Reset with `RESET_PC`=32'h100 and zero-wait memory:
  - Memory returns the address as data.
  - Required: requests to 100,104,108 on consecutive cycles.
  - Required: `o_pc`/`o_inst` equal 100/100, 104/104 … one cycle later, with `o_valid`=1 throughout.
- Stall while ack at pc=0x8, data 0xAAAA_0001:
  - IF/ID is frozen during the stall.
  - `o_memReq`=0 in HOLD.
  - After release: `o_pc`=0x8, `o_inst`=0xAAAA_0001, then the request for 0xC.
- Redirect to 0x400 while request 0x20 is waiting on 3-cycle memory:
  - `o_memAddr` stays 0x20 until ack.
  - The data from 0x20 never appears on `o_inst`.
  - Next request is 0x400; bubbles have `o_valid`=0 and `o_inst`=0.
- `i_takeBranch`=1 with `i_stall`=1, then `i_takeBranch`=0 once the stall drops: no redirect occurs and sequential fetch continues.
- Target 0x0000_0203 while in HOLD:
  - Buffer is dropped.
  - Next address is 0x200.
  - Fetch wraps from pc 0xFFFF_FFFC to 0x0.
- Reset asserted while in DISCARD: outputs match reset values the next cycle and fetch restarts at `RESET_PC`.

Source files
------------

// File: rtl/fetch_unit_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package fetch_unit_pkg;

    localparam int INST_ADDR_W = 32;
    localparam int INST_W      = 32;

    localparam logic [INST_W-1:0]      NOP_INST  = 32'h0000_0000;
    localparam logic [INST_ADDR_W-1:0] ZERO_WORD = 32'h0000_0000;

    typedef enum logic [1:0] {
        FETCH_RUN     = 2'd0,
        FETCH_DISCARD = 2'd1,
        FETCH_HOLD    = 2'd2
    } fetch_state_e;

    typedef struct packed {
        logic                   vld;
        logic [INST_ADDR_W-1:0] pc;
        logic [INST_W-1:0]      inst;
    } ifid_t;

    typedef struct packed {
        logic [INST_ADDR_W-1:0] pc;
        logic [INST_W-1:0]      inst;
    } hbuf_t;

    localparam ifid_t IFID_BUBBLE = '{vld: 1'b0, pc: ZERO_WORD, inst: NOP_INST};

    // Redirect targets are forced to word alignment.
    function automatic logic [INST_ADDR_W-1:0] align_target(input logic [INST_ADDR_W-1:0] addr);
        return addr & ~32'd3;
    endfunction

endpackage

// File: rtl/fetch_unit.sv
// IF stage + IF/ID register: one outstanding fetch, zero-wait word visible on IF/ID next cycle.
// Downstream stall freezes IF/ID; a word landing during stall is parked in a one-entry hold buffer.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    output logic        o_memReq,
    output logic [31:0] o_memAddr,
    input  logic        i_memAck,
    input  logic [31:0] i_memData,
    input  logic        i_stall,
    input  logic        i_takeBranch,
    input  logic [31:0] i_jpc,
    output logic        o_valid,
    output logic [31:0] o_pc,
    output logic [31:0] o_inst
);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  disc_addr_q, disc_addr_d;
    ifid_t        ifid_q, ifid_d;
    hbuf_t        hbuf_q, hbuf_d;

    logic         redirect;
    logic [31:0]  target;
    logic [31:0]  pc_inc;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q     <= FETCH_RUN;
            pc_q        <= RESET_PC;
            disc_addr_q <= ZERO_WORD;
            ifid_q      <= IFID_BUBBLE;
            hbuf_q      <= '0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            disc_addr_q <= disc_addr_d;
            ifid_q      <= ifid_d;
            hbuf_q      <= hbuf_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        disc_addr_d = disc_addr_q;
        ifid_d      = ifid_q;
        hbuf_d      = hbuf_q;

        redirect = i_takeBranch & ifid_q.vld & ~i_stall;
        target   = align_target(i_jpc);
        pc_inc   = pc_q + 32'd4;

        case (state_q)
            FETCH_RUN: begin
                if (redirect) begin
                    ifid_d = IFID_BUBBLE;
                    pc_d   = target;
                    // The wrong-path request stays on the bus until memory answers it.
                    if (!i_memAck) begin
                        state_d     = FETCH_DISCARD;
                        disc_addr_d = pc_q;
                    end
                end else if (i_memAck) begin
                    pc_d = pc_inc;
                    if (i_stall) begin
                        hbuf_d  = '{pc: pc_q, inst: i_memData};
                        state_d = FETCH_HOLD;
                    end else begin
                        ifid_d = '{vld: 1'b1, pc: pc_q, inst: i_memData};
                    end
                end else if (!i_stall) begin
                    ifid_d = IFID_BUBBLE;
                end
            end

            FETCH_DISCARD: begin
                if (!i_stall) ifid_d = IFID_BUBBLE;
                if (redirect) pc_d = target;
                if (i_memAck) state_d = FETCH_RUN;
            end

            FETCH_HOLD: begin
                if (redirect) begin
                    ifid_d  = IFID_BUBBLE;
                    pc_d    = target;
                    state_d = FETCH_RUN;
                end else if (!i_stall) begin
                    ifid_d  = '{vld: 1'b1, pc: hbuf_q.pc, inst: hbuf_q.inst};
                    state_d = FETCH_RUN;
                end
            end

            default: state_d = FETCH_RUN;
        endcase
    end

    assign o_memReq  = i_rst_n & (state_q != FETCH_HOLD);
    assign o_memAddr = (state_q == FETCH_DISCARD) ? disc_addr_q : pc_q;
    assign o_valid   = ifid_q.vld;
    assign o_pc      = ifid_q.pc;
    assign o_inst    = ifid_q.inst;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: memory with variable latency, stream-level reference model, directed pins.
module tb_fetch_unit;

    localparam logic [31:0] RST_PC = 32'h0000_0100;
    localparam int          LOGN   = 4096;

    logic        clk = 1'b0;
    logic        i_rst_n, o_memReq, i_memAck, i_stall, i_takeBranch, o_valid;
    logic [31:0] o_memAddr, i_memData, i_jpc, o_pc, o_inst;

    always #5 clk = ~clk;

    fetch_unit #(.RESET_PC(RST_PC)) dut (
        .i_clk       (clk),
        .i_rst_n     (i_rst_n),
        .o_memReq    (o_memReq),
        .o_memAddr   (o_memAddr),
        .i_memAck    (i_memAck),
        .i_memData   (i_memData),
        .i_stall     (i_stall),
        .i_takeBranch(i_takeBranch),
        .i_jpc       (i_jpc),
        .o_valid     (o_valid),
        .o_pc        (o_pc),
        .o_inst      (o_inst)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = -1;
    int consumed = 0;

    // memory model state
    int          lat = 0;
    bit          lat_rand = 1'b0;
    int          age = 0;
    bit          pend = 1'b0;
    logic [31:0] paddr = '0;

    logic [31:0] addr_log [LOGN];
    logic [31:0] pc_log   [LOGN];
    logic [31:0] inst_log [LOGN];
    logic        req_log  [LOGN];
    logic        valid_log[LOGN];

    function automatic logic [31:0] memfun(input logic [31:0] a);
        return (a == 32'h8) ? 32'hAAAA_0001 : a;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Memory answers only a held request, after 'lat' extra cycles.
    task automatic mem_resp();
        if (!i_rst_n) begin
            i_memAck  = 1'b0;
            i_memData = '0;
            pend      = 1'b0;
            age       = 0;
        end else begin
            if (pend) begin
                age++;
                chk("req_held", {31'b0, o_memReq}, 32'd1);
                chk("addr_held", o_memAddr, paddr);
            end else begin
                age = 0;
            end
            i_memAck  = o_memReq && (age >= lat);
            i_memData = o_memReq ? memfun(o_memAddr) : 32'h0;
            if (i_memAck && lat_rand) lat = $urandom_range(0, 3);
            pend  = o_memReq && !i_memAck;
            paddr = o_memAddr;
        end
    endtask

    task automatic step(input logic rst, input logic stall, input logic br, input logic [31:0] jpc);
        @(posedge clk);
        cyc++;
        #1;
        i_rst_n      = rst;
        i_stall      = stall;
        i_takeBranch = br;
        i_jpc        = jpc;
        #1;
        mem_resp();
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) step(1'b1, 1'b0, 1'b0, 32'h0);
    endtask

    // Reference: the sequence of instructions ID accepts must follow pc+4 / redirect target.
    logic [31:0] exp_pc = RST_PC;
    logic        prev_rst_low = 1'b0;
    logic        prev_stall   = 1'b0;
    logic        prev_valid;
    logic [31:0] prev_pc, prev_inst;

    always @(negedge clk) begin
        if (cyc >= 0 && cyc < LOGN) begin
            addr_log[cyc]  = o_memAddr;
            pc_log[cyc]    = o_pc;
            inst_log[cyc]  = o_inst;
            req_log[cyc]   = o_memReq;
            valid_log[cyc] = o_valid;
        end
        if (cyc >= 0) begin
            if (!i_rst_n) chk("req_in_reset", {31'b0, o_memReq}, 32'd0);
        end
        if (cyc >= 1) begin
            chk("valid_known", {31'b0, $isunknown(o_valid)}, 32'd0);
            if (prev_rst_low) begin
                chk("rst_valid", {31'b0, o_valid}, 32'd0);
                chk("rst_pc", o_pc, 32'h0);
                chk("rst_inst", o_inst, 32'h0);
            end else if (prev_stall) begin
                chk("frozen_valid", {31'b0, o_valid}, {31'b0, prev_valid});
                chk("frozen_pc", o_pc, prev_pc);
                chk("frozen_inst", o_inst, prev_inst);
            end
            if (o_valid === 1'b0) begin
                chk("bubble_pc", o_pc, 32'h0);
                chk("bubble_inst", o_inst, 32'h0);
            end
            if (i_rst_n && o_memReq) chk("addr_align", {30'b0, o_memAddr[1:0]}, 32'h0);
            if (!i_rst_n) begin
                exp_pc = RST_PC;
            end else if (o_valid === 1'b1 && !i_stall) begin
                chk("stream_pc", o_pc, exp_pc);
                chk("stream_inst", o_inst, memfun(exp_pc));
                consumed++;
                exp_pc = i_takeBranch ? {i_jpc[31:2], 2'b00} : exp_pc + 32'd4;
            end
        end
        prev_rst_low = !i_rst_n;
        prev_stall   = i_stall;
        prev_valid   = o_valid;
        prev_pc      = o_pc;
        prev_inst    = o_inst;
    end

    int c0, r, s, u, v, w, x;

    initial begin
        i_rst_n = 1'b0; i_stall = 1'b0; i_takeBranch = 1'b0; i_jpc = '0;
        i_memAck = 1'b0; i_memData = '0;

        // reset then zero-wait sequential fetch
        step(1'b0, 1'b0, 1'b0, 32'h0);
        step(1'b0, 1'b0, 1'b0, 32'h0);
        c0 = cyc + 1;
        run(6);
        chk("t1_req_reset", {31'b0, req_log[0]}, 32'd0);
        chk("t1_valid_reset", {31'b0, valid_log[1]}, 32'd0);
        chk("t1_pc_reset", pc_log[1], 32'h0);
        chk("t1_inst_reset", inst_log[1], 32'h0);
        for (int k = 0; k < 3; k++) begin
            chk("t1_addr", addr_log[c0+k], RST_PC + 32'(4*k));
            chk("t1_req", {31'b0, req_log[c0+k]}, 32'd1);
            chk("t1_valid", {31'b0, valid_log[c0+k+1]}, 32'd1);
            chk("t1_pc", pc_log[c0+k+1], RST_PC + 32'(4*k));
            chk("t1_inst", inst_log[c0+k+1], RST_PC + 32'(4*k));
        end

        // stall coinciding with ack at pc 0x8
        step(1'b1, 1'b0, 1'b1, 32'h4); r = cyc;
        step(1'b1, 1'b0, 1'b0, 32'h0);
        step(1'b1, 1'b1, 1'b0, 32'h0);
        step(1'b1, 1'b1, 1'b0, 32'h0);
        step(1'b1, 1'b1, 1'b0, 32'h0);
        step(1'b1, 1'b0, 1'b0, 32'h0);
        run(3);
        chk("t2_addr8", addr_log[r+2], 32'h8);
        chk("t2_hold_req0", {31'b0, req_log[r+3]}, 32'd0);
        chk("t2_hold_req1", {31'b0, req_log[r+4]}, 32'd0);
        chk("t2_frozen_pc", pc_log[r+4], 32'h4);
        chk("t2_rel_pc", pc_log[r+6], 32'h8);
        chk("t2_rel_inst", inst_log[r+6], 32'hAAAA_0001);
        chk("t2_next_addr", addr_log[r+6], 32'hC);
        chk("t2_next_req", {31'b0, req_log[r+6]}, 32'd1);

        // redirect while 0x20 waits on 3-cycle memory
        step(1'b1, 1'b0, 1'b1, 32'h18);
        run(2);
        lat = 3;
        step(1'b1, 1'b0, 1'b1, 32'h400); s = cyc;
        run(9);
        for (int k = 0; k < 4; k++) chk("t3_disc_addr", addr_log[s+k], 32'h20);
        for (int k = 1; k < 8; k++) begin
            chk("t3_bubble_valid", {31'b0, valid_log[s+k]}, 32'd0);
            chk("t3_bubble_inst", inst_log[s+k], 32'h0);
        end
        chk("t3_target_addr", addr_log[s+4], 32'h400);
        chk("t3_target_pc", pc_log[s+8], 32'h400);
        chk("t3_target_valid", {31'b0, valid_log[s+8]}, 32'd1);
        lat = 0;
        run(6);

        // branch request under stall is ignored
        step(1'b1, 1'b0, 1'b1, 32'h600); u = cyc;
        step(1'b1, 1'b0, 1'b0, 32'h0);
        step(1'b1, 1'b1, 1'b1, 32'h800);
        step(1'b1, 1'b1, 1'b1, 32'h800);
        step(1'b1, 1'b0, 1'b0, 32'h0);
        run(3);
        chk("t4_pc_stalled", pc_log[u+4], 32'h600);
        chk("t4_pc_next", pc_log[u+5], 32'h604);
        chk("t4_addr_next", addr_log[u+5], 32'h608);
        chk("t4_pc_seq", pc_log[u+6], 32'h608);

        // unaligned redirect out of HOLD, then wrap at the top of memory
        step(1'b1, 1'b0, 1'b1, 32'h300); v = cyc;
        step(1'b1, 1'b0, 1'b0, 32'h0);
        step(1'b1, 1'b1, 1'b0, 32'h0);
        step(1'b1, 1'b0, 1'b1, 32'h203);
        run(3);
        chk("t5_hold_req", {31'b0, req_log[v+3]}, 32'd0);
        chk("t5_bubble", {31'b0, valid_log[v+4]}, 32'd0);
        chk("t5_addr", addr_log[v+4], 32'h200);
        chk("t5_pc", pc_log[v+5], 32'h200);
        chk("t5_inst", inst_log[v+5], 32'h200);
        step(1'b1, 1'b0, 1'b1, 32'hFFFF_FFF8); w = cyc;
        run(5);
        chk("t5_wrap_addr_top", addr_log[w+2], 32'hFFFF_FFFC);
        chk("t5_wrap_addr0", addr_log[w+3], 32'h0);
        chk("t5_wrap_pc_top", pc_log[w+3], 32'hFFFF_FFFC);
        chk("t5_wrap_pc0", pc_log[w+4], 32'h0);
        chk("t5_wrap_valid", {31'b0, valid_log[w+4]}, 32'd1);

        // reset while discarding
        lat = 3;
        step(1'b1, 1'b0, 1'b1, 32'h500); x = cyc;
        step(1'b0, 1'b0, 1'b0, 32'h0);
        lat = 0;
        run(4);
        chk("t6_req_in_rst", {31'b0, req_log[x+1]}, 32'd0);
        chk("t6_valid", {31'b0, valid_log[x+2]}, 32'd0);
        chk("t6_pc", pc_log[x+2], 32'h0);
        chk("t6_inst", inst_log[x+2], 32'h0);
        chk("t6_addr", addr_log[x+2], RST_PC);
        chk("t6_restart_pc", pc_log[x+3], RST_PC);

        // randomized traffic
        lat_rand = 1'b1;
        for (int k = 0; k < 2000; k++) begin
            step(($urandom_range(0, 199) != 0),
                 ($urandom_range(0, 3) == 0),
                 ($urandom_range(0, 6) == 0),
                 $urandom);
        end
        run(10);
        chk("progress", {31'b0, consumed > 400}, 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
